// File: rtl/issue_queue_wakeup.sv
`default_nettype none
// ============================================================================
// Module : issue_queue_wakeup
// Unified issue queue: tag wakeup with data capture, oldest-first multi-FU select.
// Rev    : 1.0  initial release
// ============================================================================
module issue_queue_wakeup #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 2,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int OP_W   = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [DATA_W-1:0]          disp_pc,
  input  logic [DATA_W-1:0]          disp_imm,
  input  logic [PREG_W-1:0]          disp_dst,
  input  logic [ROB_W-1:0]           disp_rob,
  input  logic [PREG_W-1:0]          disp_src1_tag,
  input  logic                       disp_src1_rdy,
  input  logic [DATA_W-1:0]          disp_src1_data,
  input  logic [PREG_W-1:0]          disp_src2_tag,
  input  logic                       disp_src2_rdy,
  input  logic [DATA_W-1:0]          disp_src2_data,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]   wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [NUM_FU-1:0]          iss_valid,
  output logic [NUM_FU*OP_W-1:0]     iss_op,
  output logic [NUM_FU*DATA_W-1:0]   iss_pc,
  output logic [NUM_FU*DATA_W-1:0]   iss_src1,
  output logic [NUM_FU*DATA_W-1:0]   iss_src2,
  output logic [NUM_FU*DATA_W-1:0]   iss_imm,
  output logic [NUM_FU*PREG_W-1:0]   iss_dst,
  output logic [NUM_FU*ROB_W-1:0]    iss_rob,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  // entry storage
  logic [DEPTH-1:0]  r_valid, r_s1_rdy, r_s2_rdy;
  logic [DEPTH-1:0]  r_older [DEPTH];
  logic [OP_W-1:0]   r_op    [DEPTH];
  logic [DATA_W-1:0] r_pc    [DEPTH];
  logic [DATA_W-1:0] r_imm   [DEPTH];
  logic [PREG_W-1:0] r_dst   [DEPTH];
  logic [ROB_W-1:0]  r_rob   [DEPTH];
  logic [PREG_W-1:0] r_s1_tag[DEPTH];
  logic [PREG_W-1:0] r_s2_tag[DEPTH];
  logic [DATA_W-1:0] r_s1_data[DEPTH];
  logic [DATA_W-1:0] r_s2_data[DEPTH];

  logic [NUM_FU-1:0]        r_iss_valid;
  logic [NUM_FU*OP_W-1:0]   r_iss_op;
  logic [NUM_FU*DATA_W-1:0] r_iss_pc, r_iss_src1, r_iss_src2, r_iss_imm;
  logic [NUM_FU*PREG_W-1:0] r_iss_dst;
  logic [NUM_FU*ROB_W-1:0]  r_iss_rob;
  logic [OCC_W-1:0]         r_occ;

  logic                     w_disp_acc;
  logic [IDX_W-1:0]         w_free_idx;
  logic [DEPTH-1:0]         w_elig, w_taken, w_avail;
  logic [DEPTH-1:0]         w_col [DEPTH];
  logic [NUM_FU-1:0]        w_gnt_vld;
  logic [IDX_W-1:0]         w_gnt_idx [NUM_FU];
  logic [OCC_W-1:0]         w_ngnt;
  logic [DEPTH-1:0]         w_wk1, w_wk2;
  logic [DATA_W-1:0]        w_wk1_data [DEPTH];
  logic [DATA_W-1:0]        w_wk2_data [DEPTH];
  logic                     w_db1_hit, w_db2_hit;
  logic [DATA_W-1:0]        w_db1_data, w_db2_data;
  logic                     w_d1_rdy, w_d2_rdy;
  logic [DATA_W-1:0]        w_d1_data, w_d2_data;

  // Broadcast snoop: scanning downward lets the lowest matching port win.
  function automatic logic [DATA_W:0] f_snoop(input logic [PREG_W-1:0] tag);
    f_snoop = '0;
    for (int p = NUM_WB-1; p >= 0; p--)
      if (wb_valid[p] && wb_tag[p*PREG_W +: PREG_W] == tag)
        f_snoop = {1'b1, wb_data[p*DATA_W +: DATA_W]};
  endfunction

  assign disp_ready = (r_occ < OCC_W'(DEPTH));
  assign w_disp_acc = disp_valid & disp_ready & ~flush & (disp_op != '0);
  assign w_elig     = r_valid & r_s1_rdy & r_s2_rdy;

  always_comb begin
    {w_db1_hit, w_db1_data} = f_snoop(disp_src1_tag);
    {w_db2_hit, w_db2_data} = f_snoop(disp_src2_tag);
    w_d1_rdy  = disp_src1_rdy | w_db1_hit;
    w_d2_rdy  = disp_src2_rdy | w_db2_hit;
    w_d1_data = disp_src1_rdy ? disp_src1_data : w_db1_data;
    w_d2_data = disp_src2_rdy ? disp_src2_data : w_db2_data;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w_wk1[i], w_wk1_data[i]} = f_snoop(r_s1_tag[i]);
      {w_wk2[i], w_wk2_data[i]} = f_snoop(r_s2_tag[i]);
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
  end

  // w_col[i] holds the set of entries older than entry i
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        w_col[i][j] = r_older[j][i];
  end

  always_comb begin
    w_taken = '0;
    w_avail = '0;
    w_ngnt  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_gnt_vld[k] = 1'b0;
      w_gnt_idx[k] = '0;
      w_avail      = w_elig & ~w_taken;
      if (fu_ready[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_avail[i] && ((w_avail & w_col[i]) == '0)) begin
            w_gnt_vld[k] = 1'b1;
            w_gnt_idx[k] = IDX_W'(i);
          end
        end
      end
      if (w_gnt_vld[k]) begin
        w_taken[w_gnt_idx[k]] = 1'b1;
        w_ngnt = w_ngnt + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid  <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i]   <= '0;
        r_op[i]      <= '0;
        r_pc[i]      <= '0;
        r_imm[i]     <= '0;
        r_dst[i]     <= '0;
        r_rob[i]     <= '0;
        r_s1_tag[i]  <= '0;
        r_s2_tag[i]  <= '0;
        r_s1_data[i] <= '0;
        r_s2_data[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_s1_rdy[i] && w_wk1[i]) begin
          r_s1_rdy[i]  <= 1'b1;
          r_s1_data[i] <= w_wk1_data[i];
        end
        if (r_valid[i] && !r_s2_rdy[i] && w_wk2[i]) begin
          r_s2_rdy[i]  <= 1'b1;
          r_s2_data[i] <= w_wk2_data[i];
        end
      end
      for (int k = 0; k < NUM_FU; k++)
        if (w_gnt_vld[k]) r_valid[w_gnt_idx[k]] <= 1'b0;
      if (w_disp_acc) begin
        r_valid[w_free_idx]   <= 1'b1;
        r_op[w_free_idx]      <= disp_op;
        r_pc[w_free_idx]      <= disp_pc;
        r_imm[w_free_idx]     <= disp_imm;
        r_dst[w_free_idx]     <= disp_dst;
        r_rob[w_free_idx]     <= disp_rob;
        r_s1_tag[w_free_idx]  <= disp_src1_tag;
        r_s2_tag[w_free_idx]  <= disp_src2_tag;
        r_s1_rdy[w_free_idx]  <= w_d1_rdy;
        r_s2_rdy[w_free_idx]  <= w_d2_rdy;
        r_s1_data[w_free_idx] <= w_d1_data;
        r_s2_data[w_free_idx] <= w_d2_data;
        // New entry is younger than everything valid now, issuing or not.
        r_older[w_free_idx]   <= '0;
        for (int j = 0; j < DEPTH; j++)
          r_older[j][w_free_idx] <= r_valid[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_iss_valid <= '0;
      r_iss_op    <= '0;
      r_iss_pc    <= '0;
      r_iss_src1  <= '0;
      r_iss_src2  <= '0;
      r_iss_imm   <= '0;
      r_iss_dst   <= '0;
      r_iss_rob   <= '0;
    end else if (flush) begin
      r_iss_valid <= '0;
    end else begin
      r_iss_valid <= w_gnt_vld;
      for (int k = 0; k < NUM_FU; k++) begin
        if (w_gnt_vld[k]) begin
          r_iss_op[k*OP_W +: OP_W]       <= r_op[w_gnt_idx[k]];
          r_iss_pc[k*DATA_W +: DATA_W]   <= r_pc[w_gnt_idx[k]];
          r_iss_src1[k*DATA_W +: DATA_W] <= r_s1_data[w_gnt_idx[k]];
          r_iss_src2[k*DATA_W +: DATA_W] <= r_s2_data[w_gnt_idx[k]];
          r_iss_imm[k*DATA_W +: DATA_W]  <= r_imm[w_gnt_idx[k]];
          r_iss_dst[k*PREG_W +: PREG_W]  <= r_dst[w_gnt_idx[k]];
          r_iss_rob[k*ROB_W +: ROB_W]    <= r_rob[w_gnt_idx[k]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_occ <= '0;
    else if (flush) r_occ <= '0;
    else            r_occ <= r_occ + OCC_W'(w_disp_acc) - w_ngnt;
  end

  assign iss_valid = r_iss_valid;
  assign iss_op    = r_iss_op;
  assign iss_pc    = r_iss_pc;
  assign iss_src1  = r_iss_src1;
  assign iss_src2  = r_iss_src2;
  assign iss_imm   = r_iss_imm;
  assign iss_dst   = r_iss_dst;
  assign iss_rob   = r_iss_rob;
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_wakeup.sv
`default_nettype none
// ============================================================================
// Module : tb_issue_queue_wakeup
// Directed stimulus with a scoreboard of expected issues checked by a monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_issue_queue_wakeup;

  logic        clk = 1'b0;
  logic        rstn, flush, disp_valid, disp_ready;
  logic [3:0]  disp_op;
  logic [31:0] disp_pc, disp_imm, disp_src1_data, disp_src2_data;
  logic [5:0]  disp_dst, disp_rob, disp_src1_tag, disp_src2_tag;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [63:0] wb_data;
  logic [2:0]  fu_ready, iss_valid;
  logic [11:0] iss_op;
  logic [95:0] iss_pc, iss_src1, iss_src2, iss_imm;
  logic [17:0] iss_dst, iss_rob;
  logic [4:0]  occupancy;

  issue_queue_wakeup dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_dst(disp_dst), .disp_rob(disp_rob),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src1_data(disp_src1_data),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_src2_data(disp_src2_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_pc(iss_pc), .iss_src1(iss_src1),
    .iss_src2(iss_src2), .iss_imm(iss_imm), .iss_dst(iss_dst), .iss_rob(iss_rob),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [3:0]  op;
    logic [5:0]  rob;
    logic [31:0] s1, s2, pc, imm;
    logic [5:0]  dst;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] rob,
                       input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] d2);
    disp_valid = 1'b1; disp_op = op; disp_rob = rob;
    disp_pc = 32'h1000 + {24'h0, rob, 2'b00}; disp_imm = 32'h100 + {26'h0, rob}; disp_dst = ~rob;
    disp_src1_tag = t1; disp_src1_rdy = r1; disp_src1_data = d1;
    disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_data = d2;
  endtask

  task automatic expect_iss(input int slot, input logic [3:0] op, input logic [5:0] rob,
                            input logic [31:0] s1, input logic [31:0] s2);
    exp_t e;
    e.slot = slot; e.op = op; e.rob = rob; e.s1 = s1; e.s2 = s2;
    e.pc = 32'h1000 + {24'h0, rob, 2'b00}; e.imm = 32'h100 + {26'h0, rob}; e.dst = ~rob;
    sb.push_back(e);
  endtask

  // monitor: every issue strobe must match the next scoreboard entry
  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < 3; k++) begin
        if (iss_valid[k]) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL issue_unexpected slot%0d: got rob=%0h, required no issue", k, iss_rob[k*6 +: 6]);
          end else begin
            m_e = sb.pop_front();
            if (m_e.slot != k || iss_op[k*4 +: 4] !== m_e.op || iss_rob[k*6 +: 6] !== m_e.rob ||
                iss_src1[k*32 +: 32] !== m_e.s1 || iss_src2[k*32 +: 32] !== m_e.s2 ||
                iss_pc[k*32 +: 32] !== m_e.pc || iss_imm[k*32 +: 32] !== m_e.imm ||
                iss_dst[k*6 +: 6] !== m_e.dst) begin
              n_err++;
              $display("FAIL issue slot%0d: got op=%0h rob=%0h s1=%0h s2=%0h pc=%0h imm=%0h dst=%0h, required slot%0d op=%0h rob=%0h s1=%0h s2=%0h pc=%0h imm=%0h dst=%0h",
                       k, iss_op[k*4 +: 4], iss_rob[k*6 +: 6], iss_src1[k*32 +: 32], iss_src2[k*32 +: 32],
                       iss_pc[k*32 +: 32], iss_imm[k*32 +: 32], iss_dst[k*6 +: 6],
                       m_e.slot, m_e.op, m_e.rob, m_e.s1, m_e.s2, m_e.pc, m_e.imm, m_e.dst);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_pc = '0; disp_imm = '0;
    disp_dst = '0; disp_rob = '0; disp_src1_tag = '0; disp_src1_rdy = 1'b0; disp_src1_data = '0;
    disp_src2_tag = '0; disp_src2_rdy = 1'b0; disp_src2_data = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; fu_ready = 3'b111;
    step(); step();
    chk("reset_occ", occupancy, 0);
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_disp_ready", disp_ready, 1);
    chk("reset_iss_src1", iss_src1, 0);
    chk("reset_iss_rob", iss_rob, 0);
    rstn = 1'b1;
    step();

    // back-to-back ready ADDs: each issues on slot 0 two edges after dispatch
    expect_iss(0, 1, 6'd1, 32'h11, 32'h21);
    expect_iss(0, 1, 6'd2, 32'h12, 32'h22);
    expect_iss(0, 1, 6'd3, 32'h13, 32'h23);
    drive(1, 6'd1, 6'd0, 1, 32'h11, 6'd0, 1, 32'h21); step();
    chk("t1_occ_a", occupancy, 1); chk("t1_iss_a", iss_valid, 3'b000);
    drive(1, 6'd2, 6'd0, 1, 32'h12, 6'd0, 1, 32'h22); step();
    chk("t1_occ_b", occupancy, 1); chk("t1_iss_b", iss_valid, 3'b001);
    drive(1, 6'd3, 6'd0, 1, 32'h13, 6'd0, 1, 32'h23); step();
    chk("t1_occ_c", occupancy, 1); chk("t1_iss_c", iss_valid, 3'b001);
    disp_valid = 1'b0; step();
    chk("t1_occ_d", occupancy, 0); chk("t1_iss_d", iss_valid, 3'b001);
    step();
    chk("t1_iss_e", iss_valid, 3'b000);

    // op 0 is never accepted
    drive(0, 6'd9, 6'd0, 1, 32'h0, 6'd0, 1, 32'h0); step();
    disp_valid = 1'b0;
    chk("op0_occ", occupancy, 0);
    step();
    chk("op0_iss", iss_valid, 3'b000);

    // fill with waiting src1 tag 5, then one broadcast wakes all
    for (int i = 0; i < 16; i++) expect_iss(i % 3, 1, 6'(16 + i), 32'hDEAD, 32'(i));
    for (int i = 0; i < 16; i++) begin
      drive(1, 6'(16 + i), 6'd5, 0, 32'hFFFF_FFFF, 6'd0, 1, 32'(i)); step();
    end
    chk("full_disp_ready", disp_ready, 0);
    chk("full_occ", occupancy, 16);
    drive(1, 6'd40, 6'd0, 1, 32'h0, 6'd0, 1, 32'h0); step();
    chk("full_ignore_occ", occupancy, 16);
    disp_valid = 1'b0;
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd5}; wb_data = {32'h0, 32'h0000_DEAD}; step();
    wb_valid = 2'b00;
    chk("wake_same_edge_iss", iss_valid, 3'b000);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("wake_drain_iss", iss_valid, (c < 5) ? 3'b111 : 3'b001);
      chk("wake_drain_occ", occupancy, (c < 5) ? 13 - 3 * c : 0);
    end
    chk("wake_disp_ready", disp_ready, 1);
    step();

    // dispatch-cycle bypass, single match then duplicate-tag match
    expect_iss(0, 2, 6'd40, 32'hAAAA, 32'h1234);
    expect_iss(0, 2, 6'd41, 32'h4321, 32'hBBBB);
    drive(2, 6'd40, 6'd0, 1, 32'hAAAA, 6'd9, 0, 32'hFFFF);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd9}; wb_data = {32'h0, 32'h1234}; step();
    chk("byp_iss_a", iss_valid, 3'b000);
    drive(2, 6'd41, 6'd11, 0, 32'hFFFF, 6'd0, 1, 32'hBBBB);
    wb_valid = 2'b11; wb_tag = {6'd11, 6'd11}; wb_data = {32'h9999, 32'h4321}; step();
    disp_valid = 1'b0; wb_valid = 2'b00;
    chk("byp_iss_b", iss_valid, 3'b001);
    step();
    chk("byp_iss_c", iss_valid, 3'b001);
    step();

    // wakeup in queue: dual-port same tag, then port-1-only match
    expect_iss(0, 3, 6'd42, 32'h5555, 32'h42);
    expect_iss(0, 3, 6'd43, 32'h43, 32'h7777);
    drive(3, 6'd42, 6'd7, 0, 32'hFFFF, 6'd0, 1, 32'h42); step();
    drive(3, 6'd43, 6'd0, 1, 32'h43, 6'd8, 0, 32'hFFFF); step();
    disp_valid = 1'b0;
    wb_valid = 2'b11; wb_tag = {6'd7, 6'd7}; wb_data = {32'h6666, 32'h5555}; step();
    chk("wk_dual_iss", iss_valid, 3'b000);
    wb_valid = 2'b10; wb_tag = {6'd8, 6'd3}; wb_data = {32'h7777, 32'h3333}; step();
    wb_valid = 2'b00;
    chk("wk_a_iss", iss_valid, 3'b001);
    step();
    chk("wk_b_iss", iss_valid, 3'b001);
    step();

    // age order after churn: A sits at a higher index than younger B
    fu_ready = 3'b000;
    expect_iss(0, 4, 6'd50, 32'h50, 32'h50);
    expect_iss(1, 4, 6'd51, 32'h51, 32'h51);
    expect_iss(1, 4, 6'd52, 32'h52, 32'h52);
    expect_iss(1, 4, 6'd53, 32'h53, 32'h53);
    drive(4, 6'd50, 6'd0, 1, 32'h50, 6'd0, 1, 32'h50); step();
    drive(4, 6'd51, 6'd0, 1, 32'h51, 6'd0, 1, 32'h51); step();
    disp_valid = 1'b0; fu_ready = 3'b001; step();
    chk("age_f_iss", iss_valid, 3'b001);
    fu_ready = 3'b000;
    drive(4, 6'd52, 6'd0, 1, 32'h52, 6'd0, 1, 32'h52); step();
    drive(4, 6'd53, 6'd0, 1, 32'h53, 6'd0, 1, 32'h53); step();
    disp_valid = 1'b0; fu_ready = 3'b010; step();
    chk("age_a_iss", iss_valid, 3'b010);
    step();
    chk("age_b_iss", iss_valid, 3'b010);
    step();
    chk("age_c_iss", iss_valid, 3'b010);
    chk("age_occ", occupancy, 0);
    fu_ready = 3'b111; step();

    // flush with 8 ready entries and a same-cycle dispatch
    fu_ready = 3'b000;
    for (int i = 0; i < 8; i++) begin
      drive(5, 6'(60 + i), 6'd0, 1, 32'h60, 6'd0, 1, 32'h60); step();
    end
    chk("pre_flush_occ", occupancy, 8);
    drive(5, 6'd59, 6'd0, 1, 32'h59, 6'd0, 1, 32'h59);
    flush = 1'b1; fu_ready = 3'b111; step();
    flush = 1'b0; disp_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_iss", iss_valid, 3'b000);
    chk("flush_disp_ready", disp_ready, 1);
    step();
    chk("post_flush_iss", iss_valid, 3'b000);
    chk("post_flush_occ", occupancy, 0);

    // asynchronous reset with issue-ready entries pending
    fu_ready = 3'b000;
    drive(6, 6'd30, 6'd0, 1, 32'h30, 6'd0, 1, 32'h30); step();
    drive(6, 6'd31, 6'd0, 1, 32'h31, 6'd0, 1, 32'h31); step();
    disp_valid = 1'b0;
    chk("pre_rst_occ", occupancy, 2);
    fu_ready = 3'b111;
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_occ", occupancy, 0);
    chk("async_rst_iss", iss_valid, 3'b000);
    step();
    chk("rst_hold_iss", iss_valid, 3'b000);
    rstn = 1'b1; step();
    chk("post_rst_iss", iss_valid, 3'b000);
    chk("post_rst_occ", occupancy, 0);
    step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
